instruction_fetch_register: RTL and testbench

INSTRUCTION_FETCH_REGISTER -- requirements
Module: instruction_fetch_register

---
 rtl/ir_pkg.sv | 14 +
 rtl/ir_assembler.sv | 47 ++++
 rtl/instruction_fetch_register.sv | 88 ++++++++
 tb/tb_instruction_fetch_register.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared types and default sizing for the instruction fetch register.
package ir_pkg;

  localparam int IR_BYTE_W    = 8;
  localparam int IR_NUM_BYTES = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL      = 2'd1,
    HOLD      = 2'd2,
    HOLD_FILL = 2'd3
  } ir_state_e;

endpackage

// File: rtl/ir_assembler.sv
// Byte assembly buffer and byte counter; exposes the buffer with the incoming
// byte already merged so the top can load a complete word on the last accept.
module ir_assembler
  import ir_pkg::*;
#(
  parameter int BYTE_W    = IR_BYTE_W,
  parameter int NUM_BYTES = IR_NUM_BYTES
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          flush,
  input  logic                          accept,
  input  logic [BYTE_W-1:0]             byte_in,
  output logic [$clog2(NUM_BYTES)-1:0]  count,
  output logic                          last,
  output logic [NUM_BYTES*BYTE_W-1:0]   merged
);

  localparam int CNT_W = $clog2(NUM_BYTES);
  localparam int IR_W  = NUM_BYTES * BYTE_W;

  logic [IR_W-1:0] buf_q;

  assign last = (count == CNT_W'(NUM_BYTES - 1));

  always_comb begin
    merged = buf_q;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (count == CNT_W'(k)) merged[k*BYTE_W +: BYTE_W] = byte_in;
    end
  end

  // Stale upper slices left after a flush are harmless: every slice is
  // rewritten before the next completion.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      buf_q <= '0;
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (accept) begin
      buf_q <= merged;
      count <= last ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/instruction_fetch_register.sv
// Instruction fetch register: assembles NUM_BYTES bytes into one instruction word.
// Macro IR_PREFETCH_EN allows the next instruction to assemble while one is held.
module instruction_fetch_register
  import ir_pkg::*;
#(
  parameter int BYTE_W    = IR_BYTE_W,
  parameter int NUM_BYTES = IR_NUM_BYTES
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [BYTE_W-1:0]             I,
  input  logic                          ByteValid,
  output logic                          ByteReady,
  input  logic                          Flush,
  input  logic                          IRAck,
  output logic                          IRValid,
  output logic [NUM_BYTES*BYTE_W-1:0]   IROut,
  output logic [$clog2(NUM_BYTES)-1:0]  ByteCount
);

  localparam int IR_W = NUM_BYTES * BYTE_W;

  ir_state_e       state_q, state_d;
  logic            accept;
  logic            last;
  logic [IR_W-1:0] merged;

  assign IRValid = (state_q == HOLD) || (state_q == HOLD_FILL);

`ifdef IR_PREFETCH_EN
  // Only stall when the final byte would complete a word nobody has taken yet.
  assign ByteReady = !Reset && !(IRValid && !IRAck && last);
`else
  assign ByteReady = !Reset && !IRValid;
`endif

  assign accept = ByteValid && ByteReady && !Flush;

  ir_assembler #(
    .BYTE_W    (BYTE_W),
    .NUM_BYTES (NUM_BYTES)
  ) u_asm (
    .Clock   (Clock),
    .Reset   (Reset),
    .flush   (Flush),
    .accept  (accept),
    .byte_in (I),
    .count   (ByteCount),
    .last    (last),
    .merged  (merged)
  );

  always_comb begin
    state_d = state_q;
    if (Flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (accept) state_d = last ? HOLD : FILL;
        FILL: if (accept && last) state_d = HOLD;
`ifdef IR_PREFETCH_EN
        HOLD: begin
          if (IRAck)       state_d = accept ? FILL : IDLE;
          else if (accept) state_d = HOLD_FILL;
        end
        HOLD_FILL: begin
          if (accept && last) state_d = HOLD;
          else if (IRAck)     state_d = FILL;
        end
`else
        HOLD: if (IRAck) state_d = IDLE;
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      IROut   <= '0;
    end else begin
      state_q <= state_d;
      if (accept && last) IROut <= merged;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_register.sv
// Randomized and directed bench for instruction_fetch_register with 2- and 4-byte instances.
module tb_instruction_fetch_register;

  logic        Clock;
  logic        Reset;
  logic [7:0]  I;
  logic        ByteValid;
  logic        Flush;
  logic        IRAck;

  logic        rdy2, irv2;
  logic [15:0] ir2;
  logic [0:0]  cnt2;
  logic        rdy4, irv4;
  logic [31:0] ir4;
  logic [1:0]  cnt4;

  int total = 0;
  int bad   = 0;

  // Behavioural model: per instance byte count, pending word, held word, valid.
  int          nb[2] = '{2, 4};
  int          m_cnt[2];
  logic [63:0] m_pend[2];
  logic [63:0] m_ir[2];
  bit          m_irv[2];

  instruction_fetch_register #(.BYTE_W(8), .NUM_BYTES(2)) dut2 (
    .Clock(Clock), .Reset(Reset), .I(I), .ByteValid(ByteValid), .ByteReady(rdy2),
    .Flush(Flush), .IRAck(IRAck), .IRValid(irv2), .IROut(ir2), .ByteCount(cnt2)
  );

  instruction_fetch_register #(.BYTE_W(8), .NUM_BYTES(4)) dut4 (
    .Clock(Clock), .Reset(Reset), .I(I), .ByteValid(ByteValid), .ByteReady(rdy4),
    .Flush(Flush), .IRAck(IRAck), .IRValid(irv4), .IROut(ir4), .ByteCount(cnt4)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_pend[i] = '0; m_ir[i] = '0; m_irv[i] = 1'b0;
    end
  endfunction

  function automatic bit m_ready(input int i, input bit ack);
`ifdef IR_PREFETCH_EN
    return !(m_irv[i] && !ack && (m_cnt[i] == nb[i] - 1));
`else
    if (ack) begin end
    return !m_irv[i];
`endif
  endfunction

  function automatic void m_step(input int i, input bit acc, input logic [7:0] b,
                                 input bit fl, input bit ack);
    bit taken;
    if (fl) begin
      m_cnt[i] = 0;
      m_irv[i] = 1'b0;
      return;
    end
    taken = m_irv[i] && ack;
    if (acc) begin
      if (m_cnt[i] == 0) m_pend[i] = 64'(b);
      else               m_pend[i] = m_pend[i] | (64'(b) << (8 * m_cnt[i]));
      if (m_cnt[i] == nb[i] - 1) begin
        m_ir[i]  = m_pend[i];
        m_irv[i] = 1'b1;
        m_cnt[i] = 0;
        return;
      end
      m_cnt[i]++;
    end
    if (taken) m_irv[i] = 1'b0;
  endfunction

  // One clock cycle: drive, check ready before the edge, step model, check state after.
  task automatic cyc(input bit bv, input logic [7:0] b, input bit fl, input bit ack);
    bit r0, r1;
    ByteValid = bv; I = b; Flush = fl; IRAck = ack;
    #1;
    r0 = m_ready(0, ack);
    r1 = m_ready(1, ack);
    chk("ready2", 64'(rdy2), 64'(r0));
    chk("ready4", 64'(rdy4), 64'(r1));
    @(posedge Clock);
    m_step(0, bv && r0 && !fl, b, fl, ack);
    m_step(1, bv && r1 && !fl, b, fl, ack);
    #1;
    chk("irvalid2", 64'(irv2), 64'(m_irv[0]));
    chk("irout2",   64'(ir2),  m_ir[0]);
    chk("count2",   64'(cnt2), 64'(m_cnt[0]));
    chk("irvalid4", 64'(irv4), 64'(m_irv[1]));
    chk("irout4",   64'(ir4),  m_ir[1]);
    chk("count4",   64'(cnt4), 64'(m_cnt[1]));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready2"}, 64'(rdy2), 64'd0);
    chk({tag, "_irv2"},   64'(irv2), 64'd0);
    chk({tag, "_ir2"},    64'(ir2),  64'd0);
    chk({tag, "_cnt2"},   64'(cnt2), 64'd0);
    chk({tag, "_ready4"}, 64'(rdy4), 64'd0);
    chk({tag, "_irv4"},   64'(irv4), 64'd0);
    chk({tag, "_ir4"},    64'(ir4),  64'd0);
    chk({tag, "_cnt4"},   64'(cnt4), 64'd0);
  endtask

  initial begin
    Reset = 1'b1; ByteValid = 1'b1; I = 8'hFF; Flush = 1'b0; IRAck = 1'b0;
    m_reset();
    @(posedge Clock); @(posedge Clock); #1;
    chk_reset_outputs("reset");
    Reset = 1'b0;

    // Two-byte assembly, little-endian byte order
    cyc(1'b1, 8'h34, 1'b0, 1'b0);
    cyc(1'b1, 8'h12, 1'b0, 1'b0);
    chk("r031_ir", 64'(ir2), 64'h1234);
    chk("r031_irv", 64'(irv2), 64'd1);
`ifndef IR_PREFETCH_EN
    cyc(1'b1, 8'h55, 1'b0, 1'b0);
    chk("r031_stall_ir", 64'(ir2), 64'h1234);
    chk("r031_stall_rdy", 64'(rdy2), 64'd0);
`endif
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

    // Flush after one byte, then a clean word
    cyc(1'b1, 8'hAB, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("r033_cnt", 64'(cnt2), 64'd0);
    cyc(1'b1, 8'h01, 1'b0, 1'b0);
    cyc(1'b1, 8'h02, 1'b0, 1'b0);
    chk("r033_ir", 64'(ir2), 64'h0201);

    // Flush together with a valid byte
    cyc(1'b1, 8'hEE, 1'b1, 1'b0);
    chk("r034_irv2", 64'(irv2), 64'd0);
    chk("r034_cnt2", 64'(cnt2), 64'd0);
    chk("r034_cnt4", 64'(cnt4), 64'd0);
    chk("r034_ir2",  64'(ir2),  64'h0201);

    // Four-byte word with ByteValid gaps
    cyc(1'b1, 8'hDD, 1'b0, 1'b0);
    cyc(1'b0, 8'h99, 1'b0, 1'b0);
    cyc(1'b1, 8'hCC, 1'b0, 1'b0);
    cyc(1'b0, 8'h99, 1'b0, 1'b0);
    cyc(1'b0, 8'h99, 1'b0, 1'b0);
    cyc(1'b1, 8'hBB, 1'b0, 1'b0);
    chk("r032_prior", 64'(irv4), 64'd0);
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("r032_ir", 64'(ir4), 64'hAABBCCDD);
    chk("r032_irv", 64'(irv4), 64'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

    // Asynchronous reset pulse in the middle of a fill
    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    Reset = 1'b1;
    #2;
    chk_reset_outputs("midreset");
    @(posedge Clock); #1;
    Reset = 1'b0;
    m_reset();
    cyc(1'b1, 8'h11, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 1'b0, 1'b0);
    chk("r035_ir", 64'(ir2), 64'h2211);

`ifdef IR_PREFETCH_EN
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 8'h34, 1'b0, 1'b0);
    cyc(1'b1, 8'h12, 1'b0, 1'b0);
    cyc(1'b1, 8'h78, 1'b0, 1'b0);
    chk("r036_held", 64'(ir2), 64'h1234);
    chk("r036_cnt", 64'(cnt2), 64'd1);
    cyc(1'b1, 8'h56, 1'b0, 1'b0);
    chk("r036_stall", 64'(ir2), 64'h1234);
    cyc(1'b1, 8'h56, 1'b0, 1'b1);
    chk("r036_ir", 64'(ir2), 64'h5678);
    chk("r036_irv", 64'(irv2), 64'd1);
`endif

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 19) == 0,
          $urandom_range(0, 2) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
